// File: rtl/spi_responder.sv
// SPI mode-0 responder: byte-wide full-duplex target with oversampled pins.
// Exposes a TX holding register and an RX result strobe to local logic.
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    state_e     state_q;
    logic [2:0] cnt_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic [7:0] hold_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       miso_q;
    logic       oe_q;
    logic       busy_q;
    logic       tx_empty_q;
    logic       overrun_q;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       reload;
    logic [7:0] reload_byte;
    logic [7:0] rx_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign rx_next   = {rx_shift_q[6:0], mosi_s};

    // A freshly loaded byte bypasses the holding register on a reload.
    assign reload_byte = tx_load    ? tx_data   :
                         tx_empty_q ? IDLE_BYTE : hold_q;

    // Reload at select, or on the first falling edge after a full byte.
    assign reload = (state_q == IDLE && cs_fall) ||
                    (state_q == ACTIVE && !cs_rise && sclk_fall && cnt_q == 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            hold_q     <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_load) begin
                hold_q     <= tx_data;
                tx_empty_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (reload) begin
                tx_shift_q <= reload_byte;
                miso_q     <= reload_byte[7];
                if (!tx_load) begin
                    tx_empty_q <= 1'b1;
                    if (tx_empty_q) begin
                        overrun_q <= 1'b1;
                    end
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        cnt_q   <= 3'd0;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        miso_q  <= 1'b0;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_next;
                        cnt_q      <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                        end
                    end else if (sclk_fall && cnt_q != 3'd0) begin
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        miso_q     <= tx_shift_q[6];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MISO     = miso_q;
    assign MISO_OE  = oe_q;
    assign tx_empty = tx_empty_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder acting as a mode-0 SPI initiator.
// Initiator half-period is 4 clk; inputs change on the falling clk edge.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SCLK = 1'b0;
    logic       CS_N = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       MISO;
    logic       MISO_OE;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int p0;
    logic [7:0] m;
    logic [7:0] m2;

    spi_responder #(
        .SYNC_STAGES(2),
        .IDLE_BYTE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SCLK(SCLK),
        .CS_N(CS_N),
        .MOSI(MOSI),
        .MISO(MISO),
        .MISO_OE(MISO_OE),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .tx_empty(tx_empty),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Shift n bits MSB first; with last set, CS_N rises with the final SCLK fall.
    task automatic spi_bits(input logic [7:0] b, input int n, input bit last,
                            output logic [7:0] rcv);
        rcv = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = b[i];
            wait_clk(4);
            SCLK = 1'b1;
            rcv[i] = MISO;
            wait_clk(4);
            SCLK = 1'b0;
            if (last && i == 8 - n) CS_N = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miso"}, {31'd0, MISO}, 32'd0);
        check({pfx, "_oe"}, {31'd0, MISO_OE}, 32'd0);
        check({pfx, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({pfx, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check({pfx, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({pfx, "_tx_empty"}, {31'd0, tx_empty}, 32'd1);
    endtask

    initial begin
        wait_clk(3);
        check_reset_outputs("rst");
        rst = 1'b1;
        wait_clk(3);

        // Single byte
        load(8'hA5);
        check("t1_loaded", {31'd0, tx_empty}, 32'd0);
        CS_N = 1'b0;
        wait_clk(4);
        check("t1_oe", {31'd0, MISO_OE}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_consumed", {31'd0, tx_empty}, 32'd1);
        p0 = pulses;
        spi_bits(8'h3C, 8, 1'b1, m);
        wait_clk(6);
        check("t1_miso", {24'd0, m}, 32'hA5);
        check("t1_rx", {24'd0, rx_data}, 32'h3C);
        check("t1_pulses", pulses, p0 + 1);
        check("t1_empty", {31'd0, tx_empty}, 32'd1);
        check("t1_overrun", {31'd0, overrun}, 32'd0);
        check("t1_oe_off", {31'd0, MISO_OE}, 32'd0);
        check("t1_busy_off", {31'd0, busy}, 32'd0);

        // Back-to-back bytes
        load(8'h11);
        CS_N = 1'b0;
        wait_clk(4);
        p0 = pulses;
        fork
            spi_bits(8'hF0, 8, 1'b0, m);
            begin
                wait_clk(20);
                load(8'h22);
            end
        join
        check("t2_miso0", {24'd0, m}, 32'h11);
        check("t2_rx0", {24'd0, rx_data}, 32'hF0);
        spi_bits(8'h0F, 8, 1'b1, m2);
        wait_clk(6);
        check("t2_miso1", {24'd0, m2}, 32'h22);
        check("t2_rx1", {24'd0, rx_data}, 32'h0F);
        check("t2_pulses", pulses, p0 + 2);
        check("t2_overrun", {31'd0, overrun}, 32'd0);
        check("t2_empty", {31'd0, tx_empty}, 32'd1);

        // Underrun
        CS_N = 1'b0;
        wait_clk(4);
        check("t3_overrun_set", {31'd0, overrun}, 32'd1);
        spi_bits(8'h55, 8, 1'b1, m);
        wait_clk(6);
        check("t3_miso", {24'd0, m}, 32'h00);
        check("t3_overrun", {31'd0, overrun}, 32'd1);
        check("t3_rx", {24'd0, rx_data}, 32'h55);
        load(8'hAA);
        check("t3_overrun_clr", {31'd0, overrun}, 32'd0);
        check("t3_empty_clr", {31'd0, tx_empty}, 32'd0);

        // Aborted transfer after five bits
        p0 = pulses;
        CS_N = 1'b0;
        wait_clk(4);
        spi_bits(8'hE7, 5, 1'b0, m);
        wait_clk(2);
        CS_N = 1'b1;
        wait_clk(6);
        check("t4_partial_miso", {24'd0, m & 8'hF8}, 32'hA8);
        check("t4_pulses", pulses, p0);
        check("t4_rx_kept", {24'd0, rx_data}, 32'h55);
        check("t4_oe", {31'd0, MISO_OE}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_miso_low", {31'd0, MISO}, 32'd0);
        load(8'h5A);
        CS_N = 1'b0;
        wait_clk(4);
        spi_bits(8'hC3, 8, 1'b1, m);
        wait_clk(6);
        check("t4_next_miso", {24'd0, m}, 32'h5A);
        check("t4_next_rx", {24'd0, rx_data}, 32'hC3);
        check("t4_next_pulses", pulses, p0 + 1);

        // Idle noise
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            MOSI = 1'($urandom);
            SCLK = ~SCLK;
            wait_clk(5);
        end
        MOSI = 1'b0;
        wait_clk(4);
        check("t5_pulses", pulses, p0);
        check("t5_oe", {31'd0, MISO_OE}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_rx", {24'd0, rx_data}, 32'hC3);

        // Reset mid-transfer
        load(8'h96);
        CS_N = 1'b0;
        wait_clk(4);
        spi_bits(8'hFF, 3, 1'b0, m);
        check("t6_partial_miso", {24'd0, m & 8'hE0}, 32'h80);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(negedge clk);
        CS_N = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(3);
        load(8'h7E);
        CS_N = 1'b0;
        wait_clk(4);
        p0 = pulses;
        spi_bits(8'h81, 8, 1'b1, m);
        wait_clk(6);
        check("t6_miso", {24'd0, m}, 32'h7E);
        check("t6_rx", {24'd0, rx_data}, 32'h81);
        check("t6_pulses", pulses, p0 + 1);
        check("t6_empty", {31'd0, tx_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
